// File: rtl/usb_pkg.sv
// Shared types and constants for the USB device protocol engine: PIDs, packet
// field positions, FSM state encoding and packet builders.
package usb_pkg;

   localparam int PKT_W   = 99;
   localparam int SYNC_HI = 98;
   localparam int SYNC_LO = 91;
   localparam int PID_HI  = 90;
   localparam int PID_LO  = 83;
   localparam int ADDR_HI = 82;
   localparam int ADDR_LO = 76;
   localparam int ENDP_HI = 75;
   localparam int ENDP_LO = 72;
   localparam int PAY_HI  = 82;
   localparam int PAY_LO  = 19;

   localparam logic [7:0] SYNC      = 8'h01;
   localparam logic [7:0] PID_OUT   = 8'h87;
   localparam logic [7:0] PID_IN    = 8'h96;
   localparam logic [7:0] PID_DATA0 = 8'hC3;
   localparam logic [7:0] PID_ACK   = 8'h4B;
   localparam logic [7:0] PID_NAK   = 8'h5A;

   localparam logic [3:0] MAX_ERR = 4'd8;
   localparam logic [7:0] TIMEOUT = 8'd255;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RX_WAIT = 3'd1,
      HS_SEND = 3'd2,
      TX_SEND = 3'd3,
      HS_WAIT = 3'd4
   } state_e;

   function automatic logic [PKT_W-1:0] mk_hs(input logic [7:0] pid);
      return {SYNC, pid, 83'd0};
   endfunction

   function automatic logic [PKT_W-1:0] mk_data(input logic [63:0] payload);
      return {SYNC, PID_DATA0, payload, 19'd0};
   endfunction

endpackage

// File: rtl/usb_device_protocol_if.sv
// Packet/payload bus between the protocol engine (slave) and its host-side
// decoder/encoder and application logic (master).
interface usb_device_protocol_if;
   import usb_pkg::*;

   logic [PKT_W-1:0] pktIn;
   logic             pktInAvail;
   logic             validIn;
   logic [63:0]      txData;
   logic             txDataValid;
   logic             readyEC;
   logic             nrzi_avail;
   logic [PKT_W-1:0] pktOut;
   logic             pktOutAvail;
   logic [63:0]      rxData;
   logic             rxDataValid;
   logic             txDataTaken;
   logic             done;
   logic             success;
   logic             re;

   modport slave (
      input  pktIn, pktInAvail, validIn, txData, txDataValid, readyEC, nrzi_avail,
      output pktOut, pktOutAvail, rxData, rxDataValid, txDataTaken, done, success, re
   );

   modport master (
      output pktIn, pktInAvail, validIn, txData, txDataValid, readyEC, nrzi_avail,
      input  pktOut, pktOutAvail, rxData, rxDataValid, txDataTaken, done, success, re
   );

endinterface

// File: rtl/resp_timer.sv
// Response timer: 8-bit up-counter that stops at TIMEOUT and flags expiry.
module resp_timer
   import usb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = 8'd0;
      else if (en && cnt_q != TIMEOUT)
         cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= 8'd0;
      else     cnt_q <= cnt_d;
   end

   assign expired = (cnt_q == TIMEOUT);

endmodule

// File: rtl/usb_device_protocol.sv
// USB device transaction engine for one address/endpoint: OUT receive with
// ACK/NAK, IN transmit with handshake wait, retry and error accounting.
module usb_device_protocol
   import usb_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'd5,
   parameter logic [3:0] DEV_ENDP = 4'd4
) (
   input logic                  clk,
   input logic                  rst,
   usb_device_protocol_if.slave bus
);

   state_e           state_q, state_d, hs_ret_q, hs_ret_d;
   logic             hs_succ_q, hs_succ_d;
   logic [3:0]       err_cnt_q, err_cnt_d, err_inc;
   logic [PKT_W-1:0] pkt_out_q, pkt_out_d;
   logic [63:0]      rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d, tx_taken_q, tx_taken_d;
   logic             done_q, done_d, success_q, success_d, re_q, re_d;
   logic             pkt_out_avail, tmr_clr, tmr_en, tmr_expired;
   logic [7:0]       pid;
   logic             tok_ok, rx_good, hs_ack, in_wait, wait_err, err_max;
   logic             unused_pkt_bits;

   assign pid     = bus.pktIn[PID_HI:PID_LO];
   assign tok_ok  = bus.pktInAvail && bus.validIn && (pid == PID_OUT || pid == PID_IN) &&
                    bus.pktIn[ADDR_HI:ADDR_LO] == DEV_ADDR &&
                    bus.pktIn[ENDP_HI:ENDP_LO] == DEV_ENDP;
   assign rx_good = bus.pktInAvail && bus.validIn && pid == PID_DATA0;
   assign hs_ack  = bus.pktInAvail && bus.validIn && pid == PID_ACK;
   assign in_wait = (state_q == RX_WAIT) || (state_q == HS_WAIT);
   // Any packet other than the expected one, or silence past the timeout, is a retryable error
   assign wait_err = in_wait && (bus.pktInAvail || tmr_expired) &&
                     !((state_q == RX_WAIT) ? rx_good : hs_ack);
   assign err_inc  = err_cnt_q + 4'd1;
   assign err_max  = (err_inc == MAX_ERR);
   assign unused_pkt_bits = ^{bus.pktIn[SYNC_HI:SYNC_LO], bus.pktIn[PAY_LO-1:0]};

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:
            if (tok_ok)
               state_d = (pid == PID_OUT) ? RX_WAIT : (bus.txDataValid ? TX_SEND : HS_SEND);
         RX_WAIT:
            if (rx_good)       state_d = HS_SEND;
            else if (wait_err) state_d = err_max ? IDLE : (bus.pktInAvail ? HS_SEND : RX_WAIT);
         HS_SEND:
            if (bus.readyEC) state_d = hs_ret_q;
         TX_SEND:
            if (bus.readyEC) state_d = HS_WAIT;
         HS_WAIT:
            if (hs_ack)        state_d = IDLE;
            else if (wait_err) state_d = err_max ? IDLE : TX_SEND;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pkt_out_avail = (state_q == HS_SEND) || (state_q == TX_SEND);
      pkt_out_d     = pkt_out_q;
      hs_ret_d      = hs_ret_q;
      hs_succ_d     = hs_succ_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      tx_taken_d    = 1'b0;
      done_d        = 1'b0;
      success_d     = 1'b0;
      err_cnt_d     = err_cnt_q;

      // Outgoing packet is captured on entry so it holds steady while the encoder stalls
      if (state_d != state_q) begin
         if (state_d == HS_SEND) begin
            hs_succ_d = (state_q == RX_WAIT) && rx_good;
            hs_ret_d  = (state_q == RX_WAIT && !rx_good) ? RX_WAIT : IDLE;
            pkt_out_d = mk_hs(((state_q == RX_WAIT) && rx_good) ? PID_ACK : PID_NAK);
         end else if (state_d == TX_SEND) begin
            pkt_out_d = mk_data(bus.txData);
         end
      end

      if (state_q == RX_WAIT && rx_good) begin
         rx_data_d  = bus.pktIn[PAY_HI:PAY_LO];
         rx_valid_d = 1'b1;
      end

      if (state_q == HS_SEND && bus.readyEC && hs_ret_q == IDLE) begin
         done_d    = 1'b1;
         success_d = hs_succ_q;
      end else if (state_q == HS_WAIT && hs_ack) begin
         done_d     = 1'b1;
         success_d  = 1'b1;
         tx_taken_d = 1'b1;
      end else if (wait_err && err_max) begin
         done_d = 1'b1;
      end

      if (state_d == IDLE) err_cnt_d = 4'd0;
      else if (wait_err)   err_cnt_d = err_inc;

      tmr_clr = ((state_d == RX_WAIT) || (state_d == HS_WAIT)) &&
                ((state_d != state_q) || tmr_expired);
      tmr_en  = in_wait;
      re_d    = ((state_d == RX_WAIT) || (state_d == HS_WAIT)) && !bus.nrzi_avail;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_out_q  <= '0;
         hs_ret_q   <= IDLE;
         hs_succ_q  <= 1'b0;
         err_cnt_q  <= 4'd0;
         rx_data_q  <= 64'd0;
         rx_valid_q <= 1'b0;
         tx_taken_q <= 1'b0;
         done_q     <= 1'b0;
         success_q  <= 1'b0;
         re_q       <= 1'b0;
      end else begin
         pkt_out_q  <= pkt_out_d;
         hs_ret_q   <= hs_ret_d;
         hs_succ_q  <= hs_succ_d;
         err_cnt_q  <= err_cnt_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_taken_q <= tx_taken_d;
         done_q     <= done_d;
         success_q  <= success_d;
         re_q       <= re_d;
      end
   end

   resp_timer u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   assign bus.pktOut      = pkt_out_q;
   assign bus.pktOutAvail = pkt_out_avail;
   assign bus.rxData      = rx_data_q;
   assign bus.rxDataValid = rx_valid_q;
   assign bus.txDataTaken = tx_taken_q;
   assign bus.done        = done_q;
   assign bus.success     = success_q;
   assign bus.re          = re_q;

endmodule

// File: tb/tb_usb_device_protocol.sv
// Bench for usb_device_protocol: token vector table plus hand sequences for
// retries, timeout, encoder stall and reset abort; outputs checked by scoreboard.
module tb_usb_device_protocol;
   import usb_pkg::*;

   logic clk = 1'b0;
   logic rst;
   usb_device_protocol_if bus ();

   usb_device_protocol #(.DEV_ADDR(7'd5), .DEV_ENDP(4'd4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic [98:0] q_pkt[$];
   logic [63:0] q_rx[$];
   logic        q_done[$];
   logic        q_taken[$];

   typedef struct {
      logic [7:0]  pid;
      logic [6:0]  addr;
      logic [3:0]  endp;
      logic        valid;
      logic        txv;
      logic [63:0] data;
      int          resp;  // 0 ignored, 1 NAK, 2 IN data + ACK, 3 OUT data + ACK
   } vec_t;

   vec_t vecs[8];

   function automatic logic [98:0] tb_tok(input logic [7:0] p, input logic [6:0] a, input logic [3:0] e);
      return {8'h01, p, a, e, 72'h0};
   endfunction
   function automatic logic [98:0] tb_hs(input logic [7:0] p);
      return {8'h01, p, 83'h0};
   endfunction
   function automatic logic [98:0] tb_dat(input logic [63:0] d);
      return {8'h01, 8'hC3, d, 19'h0};
   endfunction

   task automatic chk(input string nm, input logic [98:0] act, input logic [98:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input logic [98:0] p, input logic v);
      bus.pktIn      = p;
      bus.pktInAvail = 1'b1;
      bus.validIn    = v;
      tick();
      bus.pktIn      = '0;
      bus.pktInAvail = 1'b0;
      bus.validIn    = 1'b0;
   endtask

   task automatic drained(input string nm);
      chk(nm, q_pkt.size() + q_rx.size() + q_done.size() + q_taken.size(), 0);
   endtask

   // Scoreboard side: every observed output event must match the oldest expectation
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.pktOutAvail && bus.readyEC) begin
            chk("pkt_expected", q_pkt.size() != 0, 1'b1);
            if (q_pkt.size() != 0) chk("pktOut", bus.pktOut, q_pkt.pop_front());
         end
         if (bus.rxDataValid) begin
            chk("rx_expected", q_rx.size() != 0, 1'b1);
            if (q_rx.size() != 0) chk("rxData", bus.rxData, q_rx.pop_front());
         end
         if (bus.done) begin
            chk("done_expected", q_done.size() != 0, 1'b1);
            if (q_done.size() != 0) chk("success", bus.success, q_done.pop_front());
         end
         if (bus.txDataTaken) begin
            chk("taken_expected", q_taken.size() != 0, 1'b1);
            if (q_taken.size() != 0) void'(q_taken.pop_front());
         end
      end
   end

   initial begin
      vecs[0] = '{8'h87, 7'd5, 4'd4, 1'b1, 1'b0, 64'hDEADBEEF_CAFEF00D, 3};
      vecs[1] = '{8'h96, 7'd5, 4'd4, 1'b1, 1'b1, 64'h0000_0000_0000_1234, 2};
      vecs[2] = '{8'h96, 7'd5, 4'd4, 1'b1, 1'b0, 64'h0, 1};
      vecs[3] = '{8'h87, 7'd6, 4'd4, 1'b1, 1'b0, 64'h0, 0};
      vecs[4] = '{8'h96, 7'd5, 4'd3, 1'b1, 1'b1, 64'h55, 0};
      vecs[5] = '{8'h87, 7'd5, 4'd4, 1'b0, 1'b0, 64'h0, 0};
      vecs[6] = '{8'hC3, 7'd5, 4'd4, 1'b1, 1'b0, 64'h0, 0};
      vecs[7] = '{8'h87, 7'd5, 4'd4, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3};

      rst = 1'b1;
      bus.pktIn = '0; bus.pktInAvail = 1'b0; bus.validIn = 1'b0;
      bus.txData = '0; bus.txDataValid = 1'b0; bus.readyEC = 1'b1; bus.nrzi_avail = 1'b0;
      tick(); tick();
      chk("rst_pktOut", bus.pktOut, '0);
      chk("rst_avail", bus.pktOutAvail, 1'b0);
      chk("rst_rxData", bus.rxData, '0);
      chk("rst_rxValid", bus.rxDataValid, 1'b0);
      chk("rst_taken", bus.txDataTaken, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_success", bus.success, 1'b0);
      chk("rst_re", bus.re, 1'b0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         bus.txData      = vecs[i].data;
         bus.txDataValid = vecs[i].txv;
         case (vecs[i].resp)
            1: begin q_pkt.push_back(tb_hs(8'h5A)); q_done.push_back(1'b0); end
            2: q_pkt.push_back(tb_dat(vecs[i].data));
            default: ;
         endcase
         send_pkt(tb_tok(vecs[i].pid, vecs[i].addr, vecs[i].endp), vecs[i].valid);
         case (vecs[i].resp)
            0: begin
               tick(); tick();
               chk($sformatf("v%0d_ignored", i), bus.pktOutAvail, 1'b0);
            end
            1: begin tick(); tick(); tick(); end
            2: begin
               tick();
               q_done.push_back(1'b1);
               q_taken.push_back(1'b1);
               send_pkt(tb_hs(8'h4B), 1'b1);
               tick(); tick();
            end
            default: begin
               chk($sformatf("v%0d_re", i), bus.re, 1'b1);
               q_rx.push_back(vecs[i].data);
               q_pkt.push_back(tb_hs(8'h4B));
               q_done.push_back(1'b1);
               send_pkt(tb_dat(vecs[i].data), 1'b1);
               tick(); tick(); tick();
            end
         endcase
         drained($sformatf("v%0d_drained", i));
      end

      // IN retried on NAK/corrupt handshakes; txData resampled; eighth error gives up
      bus.txDataValid = 1'b1;
      bus.txData      = 64'hA000_0000_0000_0000;
      q_pkt.push_back(tb_dat(bus.txData));
      send_pkt(tb_tok(8'h96, 7'd5, 4'd4), 1'b1);
      tick();
      for (int k = 0; k < 8; k++) begin
         bus.txData = 64'hA000_0000_0000_0001 + 64'(k);
         if (k < 7) q_pkt.push_back(tb_dat(bus.txData));
         else       q_done.push_back(1'b0);
         send_pkt(tb_hs(8'h5A), (k != 3));
         tick();
      end
      tick(); tick(); tick();
      chk("nak8_idle", dut.state_q, IDLE);
      drained("nak8_drained");

      // OUT followed by silence: one timeout, then a corrupt packet, then good data
      bus.txDataValid = 1'b0;
      send_pkt(tb_tok(8'h87, 7'd5, 4'd4), 1'b1);
      for (int k = 0; k < 250; k++) tick();
      chk("to_before", dut.err_cnt_q, 4'd0);
      for (int k = 0; k < 10; k++) tick();
      chk("to_err1", dut.err_cnt_q, 4'd1);
      chk("to_state", dut.state_q, RX_WAIT);
      q_pkt.push_back(tb_hs(8'h5A));
      send_pkt(tb_dat(64'h1), 1'b0);
      tick();
      chk("bad_err2", dut.err_cnt_q, 4'd2);
      q_rx.push_back(64'h0123_4567_89AB_CDEF);
      q_pkt.push_back(tb_hs(8'h4B));
      q_done.push_back(1'b1);
      send_pkt(tb_dat(64'h0123_4567_89AB_CDEF), 1'b1);
      tick(); tick(); tick();
      chk("to_err_clr", dut.err_cnt_q, 4'd0);
      drained("to_drained");

      // Encoder stall: NAK must hold until readyEC
      bus.readyEC = 1'b0;
      q_pkt.push_back(tb_hs(8'h5A));
      q_done.push_back(1'b0);
      send_pkt(tb_tok(8'h96, 7'd5, 4'd4), 1'b1);
      for (int k = 0; k < 10; k++) begin
         chk("stall_avail", bus.pktOutAvail, 1'b1);
         chk("stall_pkt", bus.pktOut, tb_hs(8'h5A));
         tick();
      end
      chk("stall_state", dut.state_q, HS_SEND);
      bus.readyEC = 1'b1;
      tick(); tick(); tick();
      drained("stall_drained");

      // Reset in HS_WAIT aborts silently
      bus.txDataValid = 1'b1;
      bus.txData      = 64'hBEEF;
      q_pkt.push_back(tb_dat(64'hBEEF));
      send_pkt(tb_tok(8'h96, 7'd5, 4'd4), 1'b1);
      tick();
      chk("hsw_state", dut.state_q, HS_WAIT);
      chk("hsw_re", bus.re, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_state", dut.state_q, IDLE);
      chk("abort_pktOut", bus.pktOut, '0);
      chk("abort_avail", bus.pktOutAvail, 1'b0);
      chk("abort_done", bus.done, 1'b0);
      chk("abort_re", bus.re, 1'b0);
      tick(); tick(); tick();
      drained("abort_drained");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/usb_device_protocol.md
USB_DEVICE_PROTOCOL -- requirements
Module: usb_device_protocol

Interface
REQ-001 SHALL have parameters DEV_ADDR (default 7'd5, own device address) and DEV_ENDP (default 4'd4, own endpoint).
REQ-002 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, synchronous and active-high.
REQ-003 SHALL have ports: pktIn  in  99  decoded packet; pktInAvail  in  1  pktIn valid this cycle; validIn  in  1  CRC/PID check passed.
REQ-004 SHALL have ports: txData  in  64  IN payload; txDataValid  in  1  payload ready; readyEC  in  1  encoder can accept; nrzi_avail  in  1  line activity.
REQ-005 SHALL have ports: pktOut  out  99  packet to encoder; pktOutAvail  out  1  pktOut valid; rxData  out  64  OUT payload; rxDataValid  out  1  one-cycle strobe.
REQ-006 SHALL have ports: txDataTaken  out  1  IN payload ACKed strobe; done  out  1  transaction end strobe; success  out  1  result, valid with done; re  out  1  read enable.

Function
REQ-007 Packet layout: [98:91] sync 8'h01; token PID [90:83], addr [82:76], endp [75:72]; data PID [90:83], payload [82:19]; handshake PID [90:83]; unused bits zero.
REQ-008 Token accepted only when pktInAvail&&validIn, PID OUT/IN, addr==DEV_ADDR, endp==DEV_ENDP; otherwise ignored, no output.
REQ-009 States: IDLE, RX_WAIT, HS_SEND, TX_SEND, HS_WAIT.
REQ-010 IDLE: accepted OUT -> RX_WAIT; accepted IN with txDataValid -> TX_SEND; accepted IN without txDataValid -> HS_SEND(NAK), then IDLE, done=1, success=0.
REQ-011 RX_WAIT: valid DATA0 -> latch payload, rxDataValid=1 next cycle, HS_SEND(ACK), then IDLE, done=1, success=1.
REQ-012 RX_WAIT: pktInAvail&&!validIn -> errCount+1, HS_SEND(NAK), then back to RX_WAIT; 255-cycle timeout -> errCount+1, RX_WAIT with timer cleared.
REQ-013 TX_SEND: pktOut={sync, DATA0 PID, txData}, then HS_WAIT.
REQ-014 HS_WAIT: valid ACK -> txDataTaken=1, done=1, success=1, IDLE; valid NAK, invalid packet, or timeout -> errCount+1, TX_SEND (txData resampled).
REQ-015 errCount 4-bit, cleared on entry to IDLE; when increment reaches 8 -> IDLE, done=1, success=0, no further packet.
REQ-016 Send handshake: pktOutAvail=1 and pktOut stable in HS_SEND/TX_SEND until cycle with readyEC=1; state advances next edge; pktOutAvail=0 elsewhere.
REQ-017 Timer cleared on entry to RX_WAIT/HS_WAIT, counts only in those states, expires at count 255.
REQ-018 re registered: 1 in RX_WAIT/HS_WAIT when nrzi_avail=0, else 0.
REQ-019 pktIn arriving in HS_SEND/TX_SEND SHALL be ignored; token in RX_WAIT/HS_WAIT counts as invalid packet.
REQ-020 done, rxDataValid, txDataTaken SHALL each be exactly one cycle wide.

Reset
REQ-021 rst=1 at a clock edge: state IDLE, errCount 0, timer 0, pktOut 0, all strobes/pktOutAvail/re/success 0, rxData 0; aborts any transaction with no done.

Structure
REQ-022 Shared package usb_pkg: state enum, PID constants (OUT 8'h87, IN 8'h96, DATA0 8'hC3, ACK 8'h4B, NAK 8'h5A), SYNC 8'h01, field bit positions, MAX_ERR=8, TIMEOUT=255.
REQ-023 Sub-module resp_timer: 8-bit counter with synchronous clear, enable, expired output.

Verification
REQ-024 OUT token addr 5 endp 4, then valid DATA0 payload 64'hDEADBEEF_CAFEF00D -> ACK packet, rxData equal, rxDataValid, done, success=1.
REQ-025 IN token, txDataValid=1, txData 64'h1234 -> DATA0 packet; host ACK -> txDataTaken, done, success=1.
REQ-026 IN token, host NAK 8 times -> 8 DATA0 sends, then done, success=0, IDLE.
REQ-027 OUT token then no data 255 cycles -> timeout, errCount 1, no packet; then valid data -> ACK.
REQ-028 Token addr 6 -> no response; readyEC=0 for 10 cycles in HS_SEND -> pktOut held, no advance.
REQ-029 rst asserted in HS_WAIT -> next cycle IDLE, all outputs 0, no done.
